ahb_master_req_ctrl: RTL

Master-side request and burst controller for the AHB_Gen interconnect. It sits between a local master command port and the per-slave arbiters. It decodes the target slave from the command address, raises that slave's `hreq`, and sequences address-phase beats as the arbiter grants them. It releases the request after the final beat, so it is the initiator end of the arbiter's `hreq`/`hgrant`/`hwait` handshake.

---
 rtl/ahb_master_req_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// AHB_package
//   Shared AHB_Gen type definitions. burst_type uses the standard HBURST
//   encoding so it can be driven straight onto the bus.
// ---------------------------------------------------------------------------
package AHB_package;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } burst_type;

endpackage

// ---------------------------------------------------------------------------
// ahb_master_req_ctrl
//   Master-side request and burst controller for the AHB_Gen interconnect.
//   It accepts one command at a time from the local master, decodes the
//   target slave from the top address bits, raises that slave's hreq and
//   steps the address phase one beat per grant. hreq drops after the last
//   beat, and completion is reported with a one-cycle xfer_done pulse.
//   A slave index outside the populated range produces a one-cycle xfer_err
//   pulse and no request.
//
// Ports
//   hclk, hreset_n          clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_addr                start byte address, word aligned
//   cmd_burst, cmd_write    burst type and direction of the command
//   hreq                    one-hot request to the per-slave arbiters
//   hgrant                  per-slave grant (arbiter gates it with ~hwait)
//   hwait                   slave wait
//   haddr, htrans           current beat address and transfer type
//   hburst, hwrite          burst type and direction latched at accept
//   xfer_done               one-cycle pulse, transaction complete
//   xfer_err                one-cycle pulse, address decode miss
//
// Every output except cmd_ready is a register.
// ---------------------------------------------------------------------------
module ahb_master_req_ctrl
    import AHB_package::*;
#(
    parameter int SLAVE_NUM = 8,
    parameter int ADDR_W    = 32
) (
    input  logic                 hclk,
    input  logic                 hreset_n,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  burst_type            cmd_burst,
    input  logic                 cmd_write,

    output logic [SLAVE_NUM-1:0] hreq,
    input  logic [SLAVE_NUM-1:0] hgrant,
    input  logic                 hwait,

    output logic [ADDR_W-1:0]    haddr,
    output logic [1:0]           htrans,
    output burst_type            hburst,
    output logic                 hwrite,

    output logic                 xfer_done,
    output logic                 xfer_err
);

    localparam int SEL_BIT = $clog2(SLAVE_NUM);

    // One bit wider than the index so SLAVE_NUM itself is representable
    // when SLAVE_NUM is a power of two.
    localparam logic [SEL_BIT:0] SEL_LIMIT = (SEL_BIT+1)'(SLAVE_NUM);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SEL_BIT-1:0]     sel_q;
    logic [SEL_BIT-1:0]     sel_d;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_d;

    logic [SLAVE_NUM-1:0]   hreq_d;
    logic [1:0]             htrans_d;
    logic [ADDR_W-1:0]      haddr_d;
    burst_type              hburst_d;
    logic                   hwrite_d;
    logic                   xfer_done_d;
    logic                   xfer_err_d;

    logic [SEL_BIT-1:0]     cmd_sel;
    logic                   sel_miss;
    logic                   beat_ok;

    // Beats remaining after the current one, loaded at accept. INCR is
    // deliberately a single beat so it lines up with the arbiter, which
    // releases the bus after one transfer for undefined-length bursts.
    function automatic logic [3:0] beats_m1(input burst_type b);
        logic [3:0] n;
        case (b)
            SINGLE, INCR:  n = 4'd0;
            WRAP4, INCR4:  n = 4'd3;
            WRAP8, INCR8:  n = 4'd7;
            default:       n = 4'd15;
        endcase
        return n;
    endfunction

    // Address of the following beat. Wrapping bursts only advance the word
    // index inside the wrap window, leaving every bit above it untouched;
    // incrementing bursts use a full-width add and may cross 1 KB.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input burst_type         b);
        logic [ADDR_W-1:0] n;
        n = a;
        case (b)
            WRAP4:   n[3:2] = a[3:2] + 2'd1;
            WRAP8:   n[4:2] = a[4:2] + 3'd1;
            WRAP16:  n[5:2] = a[5:2] + 4'd1;
            default: n      = a + ADDR_W'(4);
        endcase
        return n;
    endfunction

    assign cmd_sel   = cmd_addr[ADDR_W-1 -: SEL_BIT];
    assign sel_miss  = ({1'b0, cmd_sel} >= SEL_LIMIT);
    // hwait is folded in as well, so a grant that arrives with a stalled
    // slave never advances the burst.
    assign beat_ok   = hgrant[sel_q] & ~hwait;
    assign cmd_ready = (state_q == IDLE);

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        hreq_d      = hreq;
        htrans_d    = htrans;
        haddr_d     = haddr;
        hburst_d    = hburst;
        hwrite_d    = hwrite;
        xfer_done_d = 1'b0;
        xfer_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    haddr_d  = cmd_addr;
                    hburst_d = cmd_burst;
                    hwrite_d = cmd_write;
                    sel_d    = cmd_sel;
                    cnt_d    = beats_m1(cmd_burst);
                    if (sel_miss) begin
                        state_d    = ERR;
                        xfer_err_d = 1'b1;
                    end else begin
                        state_d  = REQ;
                        hreq_d   = SLAVE_NUM'(1) << cmd_sel;
                        htrans_d = TRANS_NONSEQ;
                    end
                end
            end

            REQ: begin
                if (beat_ok) begin
                    haddr_d = next_addr(haddr, hburst);
                    if (cnt_q == 4'd0) begin
                        state_d     = DONE;
                        hreq_d      = '0;
                        htrans_d    = TRANS_IDLE;
                        xfer_done_d = 1'b1;
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                        htrans_d = TRANS_SEQ;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            hreq      <= '0;
            htrans    <= TRANS_IDLE;
            haddr     <= '0;
            hburst    <= SINGLE;
            hwrite    <= 1'b0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            hreq      <= hreq_d;
            htrans    <= htrans_d;
            haddr     <= haddr_d;
            hburst    <= hburst_d;
            hwrite    <= hwrite_d;
            xfer_done <= xfer_done_d;
            xfer_err  <= xfer_err_d;
        end
    end

endmodule
